// File: rtl/l2_bank_ctrl.sv
// Per-bank L2 controller: 1-cycle SRAM access, RD_LATENCY response pipe, power-gating FSM.
// Optional drop counter is enabled by defining L2_BANK_DROP_CNT_EN.
module l2_bank_ctrl #(
  parameter int ADDR_MEM_WIDTH = 12,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = 9,
  parameter int RD_LATENCY     = 1,
  parameter int WAKE_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  input  logic [ADDR_MEM_WIDTH-1:0] data_add_i,
  input  logic                      data_wen_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  input  logic [BE_WIDTH-1:0]       data_be_i,
  input  logic [ID_WIDTH-1:0]       data_ID_i,
  output logic                      data_r_valid_o,
  output logic [DATA_WIDTH-1:0]     data_r_rdata_o,
  output logic [ID_WIDTH-1:0]       data_r_ID_o,
  output logic                      mem_csn_o,
  output logic                      mem_wen_o,
  output logic [ADDR_MEM_WIDTH-1:0] mem_add_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [BE_WIDTH-1:0]       mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      mem_pwr_en_o,
  input  logic                      sleep_req_i,
  output logic                      sleep_ack_o,
  output logic [15:0]               drop_cnt_o
);

  typedef enum logic [1:0] {ACTIVE, DRAIN, SLEEP, WAKE} state_t;

  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_t                             r_state;
  state_t                             w_nextState;
  logic [7:0]                         r_wakeCnt;
  logic                               r_sleepAck;
  logic [RD_LATENCY-1:0]              r_pipeValid;
  logic [RD_LATENCY-1:0]              r_pipeRead;
  logic [RD_LATENCY-1:0]              r_pipeDrop;
  logic [RD_LATENCY-1:0][ID_WIDTH-1:0] r_pipeId;
  logic                               w_serviced;
  logic                               w_access;
  logic                               w_drop;
  logic                               w_pipeEmpty;
  logic                               w_stage0Data;

  assign w_serviced   = (r_state == ACTIVE) || (r_state == DRAIN);
  assign w_access     = data_req_i & w_serviced & ~rst;
  assign w_drop       = data_req_i & ~w_serviced;
  assign w_pipeEmpty  = ~|r_pipeValid;
  assign w_stage0Data = r_pipeValid[0] & r_pipeRead[0] & ~r_pipeDrop[0];

  assign mem_csn_o    = ~w_access;
  assign mem_wen_o    = w_access ? data_wen_i : 1'b1;
  assign mem_add_o    = data_add_i;
  assign mem_wdata_o  = data_wdata_i;
  assign mem_be_o     = data_be_i;
  assign mem_pwr_en_o = (r_state != SLEEP);
  assign sleep_ack_o  = r_sleepAck;

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ACTIVE: if (sleep_req_i) w_nextState = DRAIN;
      DRAIN: begin
        if (!sleep_req_i)                   w_nextState = ACTIVE;
        else if (w_pipeEmpty && !data_req_i) w_nextState = SLEEP;
      end
      SLEEP: if (!sleep_req_i) w_nextState = WAKE;
      WAKE:  if (r_wakeCnt == WAKE_LAST) w_nextState = ACTIVE;
      default: w_nextState = ACTIVE;
    endcase
  end

  // Ack is asserted only while staying asleep, so it drops as WAKE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACTIVE;
      r_wakeCnt  <= '0;
      r_sleepAck <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_wakeCnt  <= (r_state == WAKE) ? r_wakeCnt + 8'd1 : 8'd0;
      r_sleepAck <= (r_state == SLEEP) && (w_nextState == SLEEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipeValid <= '0;
      r_pipeRead  <= '0;
      r_pipeDrop  <= '0;
      r_pipeId    <= '0;
    end else begin
      r_pipeValid[0] <= data_req_i;
      r_pipeRead[0]  <= data_wen_i;
      r_pipeDrop[0]  <= w_drop;
      r_pipeId[0]    <= data_ID_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeRead[i]  <= r_pipeRead[i-1];
        r_pipeDrop[i]  <= r_pipeDrop[i-1];
        r_pipeId[i]    <= r_pipeId[i-1];
      end
    end
  end

  assign data_r_valid_o = r_pipeValid[RD_LATENCY-1];
  assign data_r_ID_o    = r_pipeId[RD_LATENCY-1];

  // SRAM data arrives one cycle after access; longer latencies register it onward.
  generate
    if (RD_LATENCY == 1) begin : g_rdataComb
      assign data_r_rdata_o = w_stage0Data ? mem_rdata_i : '0;
    end else begin : g_rdataPipe
      logic [RD_LATENCY-2:0][DATA_WIDTH-1:0] r_rdataPipe;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdataPipe <= '0;
        end else begin
          r_rdataPipe[0] <= w_stage0Data ? mem_rdata_i : '0;
          for (int i = 1; i < RD_LATENCY - 1; i++) begin
            r_rdataPipe[i] <= r_rdataPipe[i-1];
          end
        end
      end
      assign data_r_rdata_o = r_rdataPipe[RD_LATENCY-2];
    end
  endgenerate

`ifdef L2_BANK_DROP_CNT_EN
  logic [15:0] r_dropCnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
      r_dropCnt <= r_dropCnt + 16'd1;
    end
  end
  assign drop_cnt_o = r_dropCnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/l2_bank_ctrl.md
# l2_bank_ctrl

Per-bank L2 memory controller sitting directly downstream of the L2 crossbar: one instance per slave port, consuming the crossbar's bank-side request (req/add/wen/wdata/be/ID) and returning r_valid/r_rdata/r_ID. Drives a single-port SRAM macro with a fixed 1-cycle access, adds a configurable response pipeline, and owns the bank's power-gating sequence (drain, sleep, wake). Grant to the crossbar is unconditional, so the controller never stalls requests; it answers every request exactly once.

## Interface
- ADDR_MEM_WIDTH, 12, bank word address width
- DATA_WIDTH, 64, data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- ID_WIDTH, 9, one-hot master ID width
- RD_LATENCY, 1, request-to-response cycles; legal 1..4
- WAKE_CYCLES, 4, power-up settle cycles; legal 1..255

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- data_req_i  in  1  request from crossbar
- data_add_i  in  ADDR_MEM_WIDTH  word address
- data_wen_i  in  1  1 = read, 0 = write
- data_wdata_i  in  DATA_WIDTH  write data
- data_be_i  in  BE_WIDTH  byte enables
- data_ID_i  in  ID_WIDTH  requester ID
- data_r_valid_o  out  1  response valid
- data_r_rdata_o  out  DATA_WIDTH  read data
- data_r_ID_o  out  ID_WIDTH  echoed ID
- mem_csn_o  out  1  SRAM chip select, active-low
- mem_wen_o  out  1  SRAM write enable, active-low
- mem_add_o  out  ADDR_MEM_WIDTH  SRAM address
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_be_o  out  BE_WIDTH  SRAM byte enables
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after access
- mem_pwr_en_o  out  1  bank power switch enable
- sleep_req_i  in  1  sleep request (level)
- sleep_ack_o  out  1  bank is asleep
- drop_cnt_o  out  16  saturating count of dropped requests

## Operation
- FSM states: ACTIVE, DRAIN, SLEEP, WAKE. Reset state ACTIVE.
- ACTIVE: request at cycle t drives mem_csn_o=0 combinationally in t; mem_wen_o = data_wen_i; add/wdata/be are pass-through. sleep_req_i=1 -> DRAIN.
- DRAIN: requests are still serviced. Go to SLEEP in the first cycle with response pipeline empty and no request present. sleep_req_i=0 -> ACTIVE.
- SLEEP: mem_pwr_en_o=0, sleep_ack_o=1, mem_csn_o=1. sleep_req_i=0 -> WAKE.
- WAKE: mem_pwr_en_o=1, sleep_ack_o=0, counts WAKE_CYCLES cycles, then ACTIVE. sleep_req_i re-asserted during WAKE is ignored until ACTIVE; DRAIN then follows after one cycle in ACTIVE.
- Requests in SLEEP/WAKE are dropped: SRAM not accessed, response still issued with rdata 0, drop_cnt_o += 1 (saturates at 0xFFFF).
- Response pipeline: RD_LATENCY-deep shift register of {valid, ID, read, dropped}. Response rdata = mem_rdata_i for serviced reads, 0 for writes and drops; for RD_LATENCY>1, rdata is registered through RD_LATENCY-1 stages.
- Writes also return r_valid (with ID), matching read acknowledgement.
- SRAM contents are not retained across SLEEP.

## Timing
- Reset values: data_r_valid_o=0, data_r_rdata_o=0, data_r_ID_o=0, mem_csn_o=1, mem_wen_o=1, mem_pwr_en_o=1, sleep_ack_o=0, drop_cnt_o=0.
- Request at cycle t -> data_r_valid_o=1 in cycle t+RD_LATENCY, for exactly one cycle per request.
- Back-to-back requests every cycle are sustained; responses keep request order.
- sleep_ack_o rises the cycle after the FSM enters SLEEP; falls on the cycle WAKE is entered.
- Reset in any state: FSM to ACTIVE, pipeline flushed (in-flight responses lost), power restored the next cycle.
- Simultaneous request and sleep_req_i rise in ACTIVE: request serviced; DRAIN covers its response.

## Configuration
- L2_BANK_DROP_CNT_EN: defined -> drop counter implemented as above. Not defined -> drop_cnt_o tied to 0, no counter flops; drop behaviour otherwise unchanged.

## Test plan
- RD_LATENCY=2: write 0xDEADBEEF_CAFEF00D to addr 0x010 with be=0xFF, ID=0x004, then read -> write response at t+2 with rdata 0, read response at t+2 with that data and ID 0x004.
- Requests every cycle for 16 cycles with IDs 0x001..0x100 cycling -> 16 responses, in order, IDs echoed, no gaps.
- sleep_req_i=1 while 2 reads are in flight -> both answered, then SLEEP, mem_pwr_en_o=0, sleep_ack_o=1 one cycle after.
- Read in SLEEP with ID 0x020 -> response after RD_LATENCY with rdata 0, mem_csn_o stays 1, drop_cnt_o=1.
- sleep_req_i=0 with WAKE_CYCLES=4 -> ACTIVE after 4 cycles; a request on cycle 3 of WAKE is dropped, the one on cycle 5 is serviced.
- rst asserted in DRAIN with an in-flight read -> no response, next cycle ACTIVE with mem_pwr_en_o=1 and all outputs at reset values.
